// File: rtl/operand_forward_pkg.sv
// Shared definitions for the two-operand forwarding datapath.
// Optional feature macro: OPERAND_FORWARD_ZERO_REG_EN (register 0 hardwired to zero).
package operand_forward_pkg;

    // Register address width derived from the architectural register count (at least 1 bit).
    function automatic int reg_addr_width(input int register_count);
        return (register_count > 2) ? $clog2(register_count) : 1;
    endfunction

endpackage

// File: rtl/fwd_priority_select.sv
// Youngest-first search of the in-flight result buffer for one read operand.
// Optional feature macro: OPERAND_FORWARD_ZERO_REG_EN (register 0 never matches, reads as zero).
module fwd_priority_select
    import operand_forward_pkg::*;
#(
    parameter int ForwardDepth = 1,
    parameter int AddrWidth    = 3,
    parameter int DataWidth    = 32
) (
    input  logic [ForwardDepth-1:0]                valid,
    input  logic [ForwardDepth-1:0][AddrWidth-1:0] addr,
    input  logic [ForwardDepth-1:0][DataWidth-1:0] data,
    input  logic [AddrWidth-1:0]                   read_addr,
    input  logic [DataWidth-1:0]                   rf_data,
    output logic [ForwardDepth-1:0]                hit,
    output logic [DataWidth-1:0]                   operand
);

    logic [ForwardDepth-1:0] match;

    // Per-entry match; under the zero-register option, address 0 is never forwarded.
    always_comb begin
        match = '0;
        for (int i = 0; i < ForwardDepth; i++) begin
`ifdef OPERAND_FORWARD_ZERO_REG_EN
            match[i] = valid[i] && (addr[i] == read_addr) && (addr[i] != '0);
`else
            match[i] = valid[i] && (addr[i] == read_addr);
`endif
        end
    end

    // Scan oldest to youngest so the lowest matching index overwrites older winners.
    always_comb begin
        hit     = '0;
        operand = rf_data;
        for (int i = ForwardDepth - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = '0;
                hit[i]  = 1'b1;
                operand = data[i];
            end
        end
`ifdef OPERAND_FORWARD_ZERO_REG_EN
        if (read_addr == '0) begin
            hit     = '0;
            operand = '0;
        end
`endif
    end

endmodule

// File: rtl/operand_forward_select_two_operand.sv
// Buffers in-flight write-back results and resolves two read operands from the
// youngest matching result or the register file.
// Optional feature macro: OPERAND_FORWARD_ZERO_REG_EN (register 0 hardwired to zero).
module operand_forward_select_two_operand
    import operand_forward_pkg::*;
#(
    parameter int ForwardDepth  = 1,
    parameter int RegisterCount = 8,
    parameter int DataWidth     = 32,
    localparam int RegAddrWidth = reg_addr_width(RegisterCount)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_en,
    input  logic                    Flush,
    input  logic                    WriteValid,
    input  logic [RegAddrWidth-1:0] WriteOperand,
    input  logic [DataWidth-1:0]    WriteData,
    input  logic [RegAddrWidth-1:0] ReadOperandA,
    input  logic [RegAddrWidth-1:0] ReadOperandB,
    input  logic [DataWidth-1:0]    RegFileDataA,
    input  logic [DataWidth-1:0]    RegFileDataB,
    output logic [DataWidth-1:0]    OperandA,
    output logic [DataWidth-1:0]    OperandB,
    output logic [ForwardDepth-1:0] FwdAHit,
    output logic [ForwardDepth-1:0] FwdBHit
);

    typedef struct packed {
        logic                    valid;
        logic [RegAddrWidth-1:0] addr;
        logic [DataWidth-1:0]    data;
    } fwd_entry_t;

    // Entry 0 is the youngest in-flight result.
    fwd_entry_t entries [ForwardDepth];

    logic [ForwardDepth-1:0]                   ent_valid;
    logic [ForwardDepth-1:0][RegAddrWidth-1:0] ent_addr;
    logic [ForwardDepth-1:0][DataWidth-1:0]    ent_data;

    // Shift the buffer on clk_en; only valid bits see reset/flush, which win over the shift.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            entries[0].addr <= WriteOperand;
            entries[0].data <= WriteData;
            for (int i = 1; i < ForwardDepth; i++) begin
                entries[i].addr <= entries[i-1].addr;
                entries[i].data <= entries[i-1].data;
            end
        end
        if (rst || Flush) begin
            for (int i = 0; i < ForwardDepth; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else if (clk_en) begin
            entries[0].valid <= WriteValid;
            for (int i = 1; i < ForwardDepth; i++) begin
                entries[i].valid <= entries[i-1].valid;
            end
        end
    end

    // Flatten the entry array for the search units.
    always_comb begin
        ent_valid = '0;
        ent_addr  = '0;
        ent_data  = '0;
        for (int i = 0; i < ForwardDepth; i++) begin
            ent_valid[i] = entries[i].valid;
            ent_addr[i]  = entries[i].addr;
            ent_data[i]  = entries[i].data;
        end
    end

    fwd_priority_select #(
        .ForwardDepth(ForwardDepth),
        .AddrWidth   (RegAddrWidth),
        .DataWidth   (DataWidth)
    ) u_select_a (
        .valid    (ent_valid),
        .addr     (ent_addr),
        .data     (ent_data),
        .read_addr(ReadOperandA),
        .rf_data  (RegFileDataA),
        .hit      (FwdAHit),
        .operand  (OperandA)
    );

    fwd_priority_select #(
        .ForwardDepth(ForwardDepth),
        .AddrWidth   (RegAddrWidth),
        .DataWidth   (DataWidth)
    ) u_select_b (
        .valid    (ent_valid),
        .addr     (ent_addr),
        .data     (ent_data),
        .read_addr(ReadOperandB),
        .rf_data  (RegFileDataB),
        .hit      (FwdBHit),
        .operand  (OperandB)
    );

endmodule

// File: tb/tb_operand_forward_select_two_operand.sv
// Directed bench for operand_forward_select_two_operand with ForwardDepth = 3.
// Honours OPERAND_FORWARD_ZERO_REG_EN for the zero-register case.
module tb_operand_forward_select_two_operand;

    localparam int Depth = 3;
    localparam int AW    = 3;
    localparam int DW    = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_en;
    logic             Flush;
    logic             WriteValid;
    logic [AW-1:0]    WriteOperand;
    logic [DW-1:0]    WriteData;
    logic [AW-1:0]    ReadOperandA;
    logic [AW-1:0]    ReadOperandB;
    logic [DW-1:0]    RegFileDataA;
    logic [DW-1:0]    RegFileDataB;
    logic [DW-1:0]    OperandA;
    logic [DW-1:0]    OperandB;
    logic [Depth-1:0] FwdAHit;
    logic [Depth-1:0] FwdBHit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_forward_select_two_operand #(
        .ForwardDepth (Depth),
        .RegisterCount(8),
        .DataWidth    (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .Flush       (Flush),
        .WriteValid  (WriteValid),
        .WriteOperand(WriteOperand),
        .WriteData   (WriteData),
        .ReadOperandA(ReadOperandA),
        .ReadOperandB(ReadOperandB),
        .RegFileDataA(RegFileDataA),
        .RegFileDataB(RegFileDataB),
        .OperandA    (OperandA),
        .OperandB    (OperandB),
        .FwdAHit     (FwdAHit),
        .FwdBHit     (FwdBHit)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and leave inputs changeable away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; Flush = 1'b0;
        WriteValid = 1'b0; WriteOperand = '0; WriteData = '0;
        ReadOperandA = '0; ReadOperandB = '0;
        RegFileDataA = '0; RegFileDataB = '0;

        // 1. reset, no forwarding
        tick(); tick();
        rst = 1'b0;
        ReadOperandA = 3'd3; RegFileDataA = 32'h11;
        ReadOperandB = 3'd5; RegFileDataB = 32'h22;
        settle();
        chk("rst_opA", OperandA, 32'h11);
        chk("rst_hitA", {29'd0, FwdAHit}, 32'h0);
        chk("rst_opB", OperandB, 32'h22);
        chk("rst_hitB", {29'd0, FwdBHit}, 32'h0);

        // 2. forward and age-out; same-cycle write not bypassed
        clk_en = 1'b1; WriteValid = 1'b1; WriteOperand = 3'd3; WriteData = 32'hAA;
        settle();
        chk("nobypass_hitA", {29'd0, FwdAHit}, 32'h0);
        chk("nobypass_opA", OperandA, 32'h11);
        tick();
        WriteValid = 1'b0; WriteOperand = 3'd1; WriteData = 32'hDEAD;
        settle();
        chk("age0_hitA", {29'd0, FwdAHit}, 32'b001);
        chk("age0_opA", OperandA, 32'hAA);
        tick(); settle();
        chk("age1_hitA", {29'd0, FwdAHit}, 32'b010);
        chk("age1_opA", OperandA, 32'hAA);
        tick(); settle();
        chk("age2_hitA", {29'd0, FwdAHit}, 32'b100);
        chk("age2_opA", OperandA, 32'hAA);
        tick(); settle();
        chk("aged_hitA", {29'd0, FwdAHit}, 32'b000);
        chk("aged_opA", OperandA, 32'h11);

        // 3. youngest priority, A and B on same register
        WriteValid = 1'b1; WriteOperand = 3'd5; WriteData = 32'h1;
        tick();
        WriteData = 32'h2;
        tick();
        WriteValid = 1'b0; clk_en = 1'b0;
        ReadOperandA = 3'd5; RegFileDataA = 32'h33;
        settle();
        chk("young_opB", OperandB, 32'h2);
        chk("young_hitB", {29'd0, FwdBHit}, 32'b001);
        chk("same_opA", OperandA, 32'h2);
        chk("same_hitA", {29'd0, FwdAHit}, 32'b001);

        // 4. stall then flush
        clk_en = 1'b1; WriteValid = 1'b1; WriteOperand = 3'd2; WriteData = 32'h77;
        tick();
        clk_en = 1'b0; WriteValid = 1'b1; WriteOperand = 3'd6; WriteData = 32'h66;
        ReadOperandA = 3'd2; RegFileDataA = 32'h44;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("stall_hitA", {29'd0, FwdAHit}, 32'b001);
            chk("stall_opA", OperandA, 32'h77);
            tick();
        end
        settle();
        chk("stall_old_hitB", {29'd0, FwdBHit}, 32'b010);
        chk("stall_old_opB", OperandB, 32'h2);
        Flush = 1'b1; clk_en = 1'b1; WriteValid = 1'b1; WriteOperand = 3'd4; WriteData = 32'h9;
        tick();
        Flush = 1'b0; clk_en = 1'b0; WriteValid = 1'b0;
        ReadOperandB = 3'd4; RegFileDataB = 32'h55;
        settle();
        chk("flush_hitA", {29'd0, FwdAHit}, 32'h0);
        chk("flush_opA", OperandA, 32'h44);
        chk("flush_hitB", {29'd0, FwdBHit}, 32'h0);
        chk("flush_opB", OperandB, 32'h55);

        // 5. invalid write never forwards
        clk_en = 1'b1; WriteValid = 1'b0; WriteOperand = 3'd6; WriteData = 32'h66;
        ReadOperandA = 3'd6; RegFileDataA = 32'h99;
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk("inv_hitA", {29'd0, FwdAHit}, 32'h0);
            chk("inv_opA", OperandA, 32'h99);
        end

        // 6. register 0
        WriteValid = 1'b1; WriteOperand = 3'd0; WriteData = 32'hFF;
        tick();
        WriteValid = 1'b0; clk_en = 1'b0;
        ReadOperandA = 3'd0; RegFileDataA = 32'h5;
        settle();
`ifdef OPERAND_FORWARD_ZERO_REG_EN
        chk("zero_opA", OperandA, 32'h0);
        chk("zero_hitA", {29'd0, FwdAHit}, 32'h0);
`else
        chk("zero_opA", OperandA, 32'hFF);
        chk("zero_hitA", {29'd0, FwdAHit}, 32'b001);
`endif

        // reset clears a live entry even while clk_en and Flush are active
        ReadOperandA = 3'd7; RegFileDataA = 32'h12;
        clk_en = 1'b1; WriteValid = 1'b1; WriteOperand = 3'd7; WriteData = 32'h7;
        tick();
        settle();
        chk("pre_rst_hitA", {29'd0, FwdAHit}, 32'b001);
        rst = 1'b1; Flush = 1'b1;
        tick();
        rst = 1'b0; Flush = 1'b0; clk_en = 1'b0;
        settle();
        chk("post_rst_hitA", {29'd0, FwdAHit}, 32'h0);
        chk("post_rst_opA", OperandA, 32'h12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
